// File: rtl/shift_subtract_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_subtract_divider_if
// Brief    : Start/busy/done handshake and operand/result bundle for the divider.
// Revision : 1.0
// ============================================================================
interface shift_subtract_divider_if #(
    parameter int WIDTH = 16
);
    logic               start;
    logic [2*WIDTH-1:0] dividend;
    logic [WIDTH-1:0]   divisor;
    logic               busy;
    logic               done;
    logic               error;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    // Controller side: issues operands, observes status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, error, quotient, remainder
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, error, quotient, remainder
    );
endinterface
`default_nettype wire

// File: rtl/shift_subtract_divider.sv
`default_nettype none
// ============================================================================
// Module   : shift_subtract_divider
// Brief    : Sequential restoring divider, 2W/W -> W quotient + W remainder,
//            one quotient bit per clock, MSB first.
// Revision : 1.0
// ============================================================================
module shift_subtract_divider #(
    parameter int WIDTH = 16
) (
    input  wire                          clk,
    input  wire                          rst_n,
    shift_subtract_divider_if.slave      bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    // R < D always holds, so the stored partial remainder fits in WIDTH bits;
    // the shifted trial value carries the extra bit.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_trial;
    logic             w_fits;
    logic             w_reject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        w_shifted = {r_q, q_q[WIDTH-1]};
        w_fits    = (w_shifted >= {1'b0, d_q});
        // Only used when it fits, where the difference is below D.
        w_trial   = w_shifted[WIDTH-1:0] - d_q;
        // A high half at or above the divisor means the quotient cannot fit.
        w_reject  = (bus.divisor == '0) ||
                    (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_reject) begin
                        done_d      = 1'b1;
                        error_d     = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '0;
                    end else begin
                        r_d     = bus.dividend[2*WIDTH-1:WIDTH];
                        q_d     = bus.dividend[WIDTH-1:0];
                        d_d     = bus.divisor;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r_d   = w_fits ? w_trial : w_shifted[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], w_fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    error_d     = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule
`default_nettype wire
